// File: rtl/led_animation_pkg.sv
// Shared types and the frame table for the front-panel LED animation.
package led_animation_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int NUM_FRAMES = 13;
  localparam logic [3:0] LAST_IDX = 4'(NUM_FRAMES - 1);

  localparam logic [4:0] FRAMES [NUM_FRAMES] = '{
    5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
    5'b01000, 5'b00100, 5'b00010, 5'b00001,
    5'b11111, 5'b00000, 5'b11111, 5'b00000
  };

  function automatic logic [4:0] frame_of(input logic [3:0] i);
    return (i <= LAST_IDX) ? FRAMES[i] : 5'b00000;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Frame-hold timer: pulses tick on the last cycle of each frame.
module led_step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && (cnt_q == TERM);
    cnt_d = cnt_q + CW'(1);
    if (!run || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_animation.sv
// One-shot 13-frame LED animation launched by a rising edge on active.
module led_animation
  import led_animation_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  output logic [4:0] led
);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] led_q, led_d;
  logic       active_q, active_d;
  logic       trig;
  logic       tick;

  led_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (state_q == RUN),
    .tick (tick)
  );

  always_comb begin
    active_d = active;
    trig     = active && !active_q;
    state_d  = state_q;
    idx_d    = idx_q;
    led_d    = led_q;
    unique case (state_q)
      IDLE: begin
        led_d = 5'b00000;
        if (trig) begin
          state_d = RUN;
          idx_d   = 4'd0;
          led_d   = frame_of(4'd0);
        end
      end
      RUN: begin
        // Retriggers are deliberately not looked at while running.
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            led_d   = 5'b00000;
          end else begin
            idx_d = idx_q + 4'd1;
            led_d = frame_of(idx_q + 4'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 5'b00000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      led_q    <= 5'b00000;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      led_q    <= led_d;
      active_q <= active_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_animation.sv
// Scoreboard bench: directed scenarios then random active/reset traffic.
module tb_led_animation;

  localparam int S = 4;
  localparam int BUSY = 13 * S;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       active = 1'b0;
  logic [4:0] led;

  int checks = 0;
  int failures = 0;

  logic [4:0] exp_q[$];

  int edge_n = 0;
  int start = -1;
  bit prev = 1'b0;

  led_animation #(.STEP_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .active(active),
    .led   (led)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_frame(input int k);
    if (k <= 4) return 5'(1 << k);
    if (k <= 8) return 5'(1 << (8 - k));
    return (k % 2 == 1) ? 5'h1f : 5'h00;
  endfunction

  function automatic logic [4:0] model_step(input bit a);
    edge_n++;
    if (a && !prev && (start < 0 || edge_n >= start + BUSY + 1))
      start = edge_n;
    prev = a;
    if (start >= 0 && edge_n - start < BUSY)
      return ref_frame((edge_n - start) / S);
    return 5'h00;
  endfunction

  task automatic drive(input bit a);
    @(negedge clk);
    reset  = 1'b1;
    active = a;
    exp_q.push_back(model_step(a));
  endtask

  task automatic drive_n(input bit a, input int n);
    for (int i = 0; i < n; i++) drive(a);
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (led !== 5'h00) begin
      failures++;
      $display("FAIL async_reset got=%b want=00000", led);
    end
    start = -1;
    prev  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (led !== 5'h00) begin
        failures++;
        $display("FAIL reset_hold got=%b want=00000", led);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      automatic logic [4:0] e = exp_q.pop_front();
      checks++;
      if (led !== e) begin
        failures++;
        $display("FAIL led t=%0t got=%b want=%b", $time, led, e);
      end
    end
  end

  initial begin
    bit a;
    int guard;
    // 1: reset held, then idle
    pulse_reset(4);
    drive_n(1'b0, 4);
    // 2 and 3: pulse of 10 high cycles, 50 low
    repeat (2) begin
      drive_n(1'b1, 10);
      drive_n(1'b0, 50);
    end
    // 4: held high 100 cycles
    drive_n(1'b1, 100);
    drive_n(1'b0, 10);
    // 5: second rising edge at cycle 20
    drive_n(1'b1, 5);
    drive_n(1'b0, 14);
    drive_n(1'b1, 5);
    drive_n(1'b0, 40);
    // retrigger right at the return edge and one after
    drive_n(1'b1, 1);
    drive_n(1'b0, BUSY - 1);
    drive_n(1'b1, 1);
    drive_n(1'b0, 1);
    drive_n(1'b1, 1);
    drive_n(1'b0, 60);
    // 6: reset mid-animation
    drive_n(1'b1, 5);
    drive_n(1'b0, 25);
    pulse_reset(2);
    drive_n(1'b0, 60);
    // active already high at reset release
    pulse_reset(2);
    drive_n(1'b1, 20);
    drive_n(1'b0, 40);
    // random traffic
    a = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
      drive(a);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_animation.md
# led_animation

One-shot LED animation generator for the 5-LED front panel. A rising edge on `active` launches a fixed 13-frame pattern: a bounce chase followed by two full flashes. `led` then returns to dark. It sits between the game/control logic, which pulses or holds `active`, and the board LED pins.

## Interface
Parameters:
- `STEP_CYCLES`, default 4: clock cycles each frame is held. Legal range is ≥1. Set to about 12_500_000 for a visible 0.25 s step at 50 MHz.

Ports:
- `clk`, input, 1: single system clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `active`, input, 1: trigger request, synchronous to `clk`. Only its rising edge matters.
- `led`, output, 5: LED drive, registered, 1 = lit. `led[0]` is the rightmost LED.

## Operation
- States: `IDLE` and `RUN`.
- Edge detect: register `active_q` holds the previous sample of `active`; reset value 0. A trigger is `active && !active_q`.
  - If `active` is already 1 when reset is released, it counts as an edge on the first clock.
- `IDLE`:
  - `led` = 00000.
  - On a trigger: go to `RUN`, frame index = 0, step counter = 0.
- `RUN`:
  - `led` = FRAME[index].
  - The step counter counts 0..STEP_CYCLES-1.
  - At terminal count: the counter clears and the index increments.
  - At terminal count of index 12: go to `IDLE`.
- Frame table, index 0..12:
  - 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 11111, 00000, 11111, 00000.
- Retrigger: triggers during `RUN` are ignored. The animation always completes and is not restarted or extended.
- Holding `active` high does not repeat the animation. A new 0→1 transition is required, and it is honoured only once back in `IDLE`.
- Index width is 4 bits. The step counter width is `$clog2(STEP_CYCLES)`, minimum 1 bit. No wrap beyond index 12.

## Timing
- Reset values:
  - `led` = 00000.
  - state = `IDLE`.
  - `active_q` = 0.
  - index = 0, counter = 0.
- Launch latency:
  - Clock edge E samples the trigger.
  - `led` shows 00001 immediately after E (1-cycle latency).
- Each frame is visible for exactly `STEP_CYCLES` clocks.
  - Frame 12 (00000) lasts `STEP_CYCLES` clocks, after which the block is back in `IDLE`.
  - Total busy time = 13·`STEP_CYCLES` clocks after E.
- A trigger sampled on the same edge that returns the FSM to `IDLE` is ignored. The first accepted trigger is on the following edge or later.
- Reset asserted mid-animation:
  - `led` goes to 00000 asynchronously.
  - After release, no animation resumes without a new trigger.

## Structure
- Package `led_animation_pkg` contains:
  - the `state_t` enum (`IDLE`, `RUN`);
  - `NUM_FRAMES` = 13;
  - the `FRAMES` constant array of `logic [4:0]`.
- One sub-module, `led_step_timer`:
  - parameterised by `STEP_CYCLES`;
  - inputs `clk`, `reset`, `run`;
  - outputs a one-cycle `tick` at terminal count;
  - clears when `run` = 0.
- The top level holds the edge detector, the FSM, the index register and the output register.

## Test plan
Conditions: `STEP_CYCLES`=4, 10 ns clock.
1. Reset held low for 4 cycles, then released with `active`=0 for 4 cycles. Expect `led` = 00000 throughout and state `IDLE`.
2. `active` high for 10 cycles, then low.
   - Expect `led` = 00001 one cycle after the edge.
   - Expect each frame for 4 cycles in table order, ending with 00000.
   - Expect a return to `IDLE` after 52 cycles; `led` stays 00000 for the rest of the 50-cycle gap.
3. Repeat scenario 2 after the gap. Expect an identical 52-cycle sequence, so the block re-arms.
4. `active` held high continuously for 100 cycles. Expect exactly one animation, then `led` = 00000.
5. A second rising edge on `active` at cycle 20 of an animation. Expect no change to the sequence; it still ends at cycle 52.
6. Reset pulsed low at cycle 30 of an animation. Expect `led` = 00000 at once and no resumption after release.
